serial_sub: RTL and testbench

//   Bit-serial ripple-borrow subtractor: D = A - B - Bin, one bit per clock, LSB first.

---
 rtl/serial_sub.sv | 138 +++++++++++++
 tb/tb_serial_sub.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// ---------------------------------------------------------------------------
// serial_sub
//   Bit-serial ripple-borrow subtractor computing D = A - B - Bin, one bit
//   per clock, LSB first, using a single full-subtractor cell and shift
//   registers. Valid/ready handshakes on both the operand and result sides.
//
// Parameters
//   SIZE       operand/result width in bits (SIZE >= 1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands A, B, Bin are presented
//   in_ready   block accepts operands this cycle (high only in IDLE)
//   A          minuend
//   B          subtrahend
//   Bin        borrow-in to bit 0
//   out_valid  D/Bout hold a valid result (high only in DONE)
//   out_ready  consumer takes the result this cycle
//   D          difference (A - B - Bin) mod 2^SIZE
//   Bout       per-bit borrow-out vector; Bout[SIZE-1] is the final borrow
// ---------------------------------------------------------------------------
module serial_sub #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    input  logic            Bin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] D,
    output logic [SIZE-1:0] Bout
);

    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [SIZE-1:0] a_sr;
    logic [SIZE-1:0] b_sr;
    logic [SIZE-1:0] diff_sr;
    logic [SIZE-1:0] borrow_sr;
    logic [SIZE-1:0] diff_next;
    logic [SIZE-1:0] borrow_next;
    logic [CW-1:0]   idx;
    logic            br;
    logic            d_bit;
    logic            bo_bit;
    logic            last_bit;
    logic            accept;
    logic            deliver;

    // Full-subtractor cell on the current LSBs of the operand shift registers.
    always_comb begin
        d_bit  = a_sr[0] ^ b_sr[0] ^ br;
        bo_bit = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    end

    // Results enter at the MSB and move right, so after SIZE shifts bit i
    // sits at position i. The next-value form lets the final bit be loaded
    // straight into D/Bout on the last RUN cycle (also covers SIZE=1).
    always_comb begin
        diff_next               = diff_sr >> 1;
        diff_next[SIZE-1]       = d_bit;
        borrow_next             = borrow_sr >> 1;
        borrow_next[SIZE-1]     = bo_bit;
    end

    assign last_bit  = (idx == CW'(SIZE - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)   state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    if (deliver)  state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // Control state, serial borrow and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            br    <= 1'b0;
            D     <= '0;
            Bout  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                idx <= '0;
                br  <= Bin;
            end else if (state == RUN) begin
                br <= bo_bit;
                if (last_bit) begin
                    idx  <= '0;
                    D    <= diff_next;
                    Bout <= borrow_next;
                end else begin
                    idx <= idx + CW'(1);
                end
            end
        end
    end

    // Operand and partial-result shift registers; contents are don't-care
    // outside RUN, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sr      <= A;
            b_sr      <= B;
            diff_sr   <= '0;
            borrow_sr <= '0;
        end else if (state == RUN) begin
            a_sr      <= a_sr >> 1;
            b_sr      <= b_sr >> 1;
            diff_sr   <= diff_next;
            borrow_sr <= borrow_next;
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// ---------------------------------------------------------------------------
// tb_serial_sub
//   Directed and randomized bench for serial_sub. Instance index 0 is
//   SIZE=1, index 1 is SIZE=4 (main), index 2 is SIZE=8.
// ---------------------------------------------------------------------------
module tb_serial_sub;

    logic clk;
    logic rst_n;

    logic       iv  [3];
    logic       orr [3];
    logic       ir_v[3];
    logic       ov_v[3];
    logic [7:0] d_v [3];
    logic [7:0] bo_v[3];

    logic [0:0] a1, b1, d1, bo1;
    logic [3:0] a4, b4, d4, bo4;
    logic [7:0] a8, b8, d8, bo8;
    logic       bin1, bin4, bin8;
    logic       ir1, ir4, ir8, ov1, ov4, ov8;

    int total;
    int bad;
    int acc4;

    serial_sub #(.SIZE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir1),
        .A(a1), .B(b1), .Bin(bin1), .out_valid(ov1), .out_ready(orr[0]),
        .D(d1), .Bout(bo1)
    );
    serial_sub #(.SIZE(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir4),
        .A(a4), .B(b4), .Bin(bin4), .out_valid(ov4), .out_ready(orr[1]),
        .D(d4), .Bout(bo4)
    );
    serial_sub #(.SIZE(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir8),
        .A(a8), .B(b8), .Bin(bin8), .out_valid(ov8), .out_ready(orr[2]),
        .D(d8), .Bout(bo8)
    );

    assign ir_v[0] = ir1;
    assign ir_v[1] = ir4;
    assign ir_v[2] = ir8;
    assign ov_v[0] = ov1;
    assign ov_v[1] = ov4;
    assign ov_v[2] = ov8;
    assign d_v[0]  = {7'b0, d1};
    assign d_v[1]  = {4'b0, d4};
    assign d_v[2]  = d8;
    assign bo_v[0] = {7'b0, bo1};
    assign bo_v[1] = {4'b0, bo4};
    assign bo_v[2] = bo8;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles on which the SIZE=4 instance will accept at the next edge.
    always @(negedge clk) begin
        if (iv[1] && ir4) acc4 <= acc4 + 1;
    end

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] d;
        logic [3:0] bout;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_d(input int n, input int a, input int b, input int bin);
        int r;
        r = (a - b - bin) & ((1 << n) - 1);
        return r[7:0];
    endfunction

    // Borrow out of bit i is set exactly when the low i+1 bits of A are
    // smaller than the low i+1 bits of B plus the borrow-in.
    function automatic logic [7:0] ref_bout(input int n, input int a, input int b, input int bin);
        logic [7:0] r;
        int m;
        r = '0;
        for (int i = 0; i < n; i++) begin
            m = 1 << (i + 1);
            r[i] = ((a % m) < ((b % m) + bin));
        end
        return r;
    endfunction

    task automatic set_ops(input int k, input logic [7:0] a, input logic [7:0] b, input logic bin);
        case (k)
            0: begin a1 = a[0:0]; b1 = b[0:0]; bin1 = bin; end
            1: begin a4 = a[3:0]; b4 = b[3:0]; bin4 = bin; end
            default: begin a8 = a; b8 = b; bin8 = bin; end
        endcase
    endtask

    task automatic wait_valid(input int k, output int lat);
        lat = 0;
        while (!ov_v[k] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b, input logic bin,
                          output logic [7:0] d, output logic [7:0] bo, output int lat);
        int guard;
        set_ops(k, a, b, bin);
        iv[k] = 1'b1;
        guard = 0;
        while (!ir_v[k] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        iv[k] = 1'b0;
        wait_valid(k, lat);
        d  = d_v[k];
        bo = bo_v[k];
        orr[k] = 1'b1;
        @(posedge clk); #1;
        orr[k] = 1'b0;
    endtask

    vec_t       vecs[6];
    logic [7:0] d, bo;
    int         lat;
    int         snap;
    int         sizes[3];
    int         ra, rb, rbin;
    int         seen_valid;

    initial begin
        total = 0;
        bad   = 0;
        acc4  = 0;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[k]  = 1'b0;
            orr[k] = 1'b0;
            set_ops(k, 8'd0, 8'd0, 1'b0);
        end
        sizes[0] = 1; sizes[1] = 4; sizes[2] = 8;

        vecs[0] = '{4'd9,  4'd3, 1'b0, 4'd6,  4'b0110};
        vecs[1] = '{4'd3,  4'd9, 1'b0, 4'd10, 4'b1000};
        vecs[2] = '{4'd0,  4'd0, 1'b1, 4'd15, 4'b1111};
        vecs[3] = '{4'd5,  4'd5, 1'b0, 4'd0,  4'b0000};
        vecs[4] = '{4'd15, 4'd0, 1'b1, 4'd14, 4'b0000};
        vecs[5] = '{4'd8,  4'd1, 1'b1, 4'd6,  4'b0111};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready",  {31'b0, ir4}, 32'd1);
        chk("reset_out_valid", {31'b0, ov4}, 32'd0);
        chk("reset_d",         {28'b0, d4},  32'd0);
        chk("reset_bout",      {28'b0, bo4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table on SIZE=4.
        for (int i = 0; i < 6; i++) begin
            run_op(1, {4'b0, vecs[i].a}, {4'b0, vecs[i].b}, vecs[i].bin, d, bo, lat);
            chk($sformatf("vec%0d_d", i),    {24'b0, d},  {28'b0, vecs[i].d});
            chk($sformatf("vec%0d_bout", i), {24'b0, bo}, {28'b0, vecs[i].bout});
            chk($sformatf("vec%0d_lat", i),  lat, 32'd4);
        end
        chk("idle_after_handshake", {31'b0, ir4}, 32'd1);

        // Backpressure, operand changes during RUN, in_valid held high.
        set_ops(1, 8'd9, 8'd3, 1'b0);
        iv[1] = 1'b1;
        @(posedge clk); #1;
        snap = acc4;
        set_ops(1, 8'd12, 8'd5, 1'b0);
        wait_valid(1, lat);
        chk("bp_lat",  lat, 32'd4);
        chk("bp_d",    {28'b0, d4},  32'd6);
        chk("bp_bout", {28'b0, bo4}, 32'd6);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d_valid", c), {31'b0, ov4}, 32'd1);
            chk($sformatf("bp_hold%0d_ready", c), {31'b0, ir4}, 32'd0);
            chk($sformatf("bp_hold%0d_d", c),     {28'b0, d4},  32'd6);
            chk($sformatf("bp_hold%0d_bout", c),  {28'b0, bo4}, 32'd6);
        end
        chk("bp_no_accept_busy", acc4, snap);
        orr[1] = 1'b1;
        @(posedge clk); #1;
        orr[1] = 1'b0;
        chk("bp_idle_ready", {31'b0, ir4}, 32'd1);
        chk("bp_idle_valid", {31'b0, ov4}, 32'd0);
        @(posedge clk); #1;
        iv[1] = 1'b0;
        chk("bp_reaccept_count", acc4, snap + 1);
        chk("bp_reaccept_busy",  {31'b0, ir4}, 32'd0);
        wait_valid(1, lat);
        chk("bp2_lat",  lat, 32'd4);
        chk("bp2_d",    {28'b0, d4},  32'd7);
        chk("bp2_bout", {28'b0, bo4}, 32'd7);
        orr[1] = 1'b1;
        @(posedge clk); #1;
        orr[1] = 1'b0;

        // Reset during the second RUN cycle.
        set_ops(1, 8'd9, 8'd3, 1'b0);
        iv[1] = 1'b1;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'b0, ov4}, 32'd0);
        chk("rst_mid_ready", {31'b0, ir4}, 32'd1);
        chk("rst_mid_d",     {28'b0, d4},  32'd0);
        chk("rst_mid_bout",  {28'b0, bo4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ov4) seen_valid++;
        end
        chk("rst_no_result", seen_valid, 32'd0);
        run_op(1, 8'd5, 8'd5, 1'b0, d, bo, lat);
        chk("post_rst_d",    {24'b0, d},  32'd0);
        chk("post_rst_bout", {24'b0, bo}, 32'd0);
        chk("post_rst_lat",  lat, 32'd4);

        // Random operands across SIZE=1, 4, 8.
        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 15; t++) begin
                ra   = int'($urandom_range((1 << sizes[k]) - 1, 0));
                rb   = int'($urandom_range((1 << sizes[k]) - 1, 0));
                rbin = int'($urandom_range(1, 0));
                run_op(k, ra[7:0], rb[7:0], rbin[0], d, bo, lat);
                chk($sformatf("rnd_s%0d_%0d_d", sizes[k], t),    {24'b0, d},
                    {24'b0, ref_d(sizes[k], ra, rb, rbin)});
                chk($sformatf("rnd_s%0d_%0d_bout", sizes[k], t), {24'b0, bo},
                    {24'b0, ref_bout(sizes[k], ra, rb, rbin)});
                chk($sformatf("rnd_s%0d_%0d_lat", sizes[k], t),  lat, sizes[k]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
